// File: rtl/morse_encoder.sv
// Morse encoder: a 4-deep FIFO of hex key codes is drained one character at a
// time and keyed out on morse_out with standard dot/dash/gap timing.
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    output logic       key_ready,
    output logic       morse_out,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        CGAP
    } state_t;

    localparam logic [23:0] UNIT_LOAD = 24'(UNIT_CYCLES - 1);

    // Returns {symbol count, pattern left-aligned MSB first, 1 = dash}.
    function automatic logic [7:0] char_lookup(input logic [3:0] code);
        case (code)
            4'h0:    return {3'd5, 5'b11111};
            4'h1:    return {3'd5, 5'b01111};
            4'h2:    return {3'd5, 5'b00111};
            4'h3:    return {3'd5, 5'b00011};
            4'h4:    return {3'd5, 5'b00001};
            4'h5:    return {3'd5, 5'b00000};
            4'h6:    return {3'd5, 5'b10000};
            4'h7:    return {3'd5, 5'b11000};
            4'h8:    return {3'd5, 5'b11100};
            4'h9:    return {3'd5, 5'b11110};
            4'hA:    return {3'd2, 5'b01000};
            4'hB:    return {3'd4, 5'b10000};
            4'hC:    return {3'd4, 5'b10100};
            4'hD:    return {3'd3, 5'b10000};
            4'hE:    return {3'd1, 5'b00000};
            default: return {3'd4, 5'b00100};
        endcase
    endfunction

    logic [3:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_count;
    logic        push;
    logic        pop;
    logic [7:0]  head_entry;

    state_t      state;
    state_t      state_next;
    logic [23:0] unit_cnt;
    logic [23:0] unit_next;
    logic [1:0]  reps_left;
    logic [1:0]  reps_next;
    logic [2:0]  sym_cnt;
    logic [2:0]  sym_next;
    logic [4:0]  pattern;
    logic [4:0]  pat_next;

    assign key_ready  = (fifo_count != 3'd4);
    assign push       = key_valid && key_ready;
    assign pop        = (state == IDLE) && (fifo_count != 3'd0);
    assign head_entry = char_lookup(fifo_mem[rd_ptr]);

    // Storage needs no reset: emptiness is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= key_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
            overflow <= key_valid && !key_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            unit_cnt  <= 24'd0;
            reps_left <= 2'd0;
            sym_cnt   <= 3'd0;
            pattern   <= 5'd0;
            morse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            unit_cnt  <= unit_next;
            reps_left <= reps_next;
            sym_cnt   <= sym_next;
            pattern   <= pat_next;
            morse_out <= (state == MARK);
            busy      <= (state != IDLE);
        end
    end

    // Long intervals run as repeated units: reps_left counts extra units
    // still owed after the current one, so 24 bits cover 3*UNIT_CYCLES.
    always_comb begin
        state_next = state;
        unit_next  = unit_cnt;
        reps_next  = reps_left;
        sym_next   = sym_cnt;
        pat_next   = pattern;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = MARK;
                    unit_next  = UNIT_LOAD;
                    sym_next   = head_entry[7:5];
                    pat_next   = head_entry[4:0];
                    reps_next  = head_entry[4] ? 2'd2 : 2'd0;
                end
            end
            MARK: begin
                if (unit_cnt != 24'd0) begin
                    unit_next = unit_cnt - 24'd1;
                end else if (reps_left != 2'd0) begin
                    reps_next = reps_left - 2'd1;
                    unit_next = UNIT_LOAD;
                end else if (sym_cnt > 3'd1) begin
                    state_next = GAP;
                    unit_next  = UNIT_LOAD;
                    sym_next   = sym_cnt - 3'd1;
                    pat_next   = {pattern[3:0], 1'b0};
                end else begin
                    state_next = CGAP;
                    unit_next  = UNIT_LOAD;
                    reps_next  = 2'd2;
                    sym_next   = 3'd0;
                end
            end
            GAP: begin
                if (unit_cnt != 24'd0) begin
                    unit_next = unit_cnt - 24'd1;
                end else begin
                    state_next = MARK;
                    unit_next  = UNIT_LOAD;
                    reps_next  = pattern[4] ? 2'd2 : 2'd0;
                end
            end
            CGAP: begin
                if (unit_cnt != 24'd0) begin
                    unit_next = unit_cnt - 24'd1;
                end else if (reps_left != 2'd0) begin
                    reps_next = reps_left - 2'd1;
                    unit_next = UNIT_LOAD;
                end else begin
                    state_next = IDLE;
                    unit_next  = 24'd0;
                    pat_next   = 5'd0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder at UNIT_CYCLES = 4: expected waveforms are
// built from a dot/dash table, one sample per clock taken 1 ns after posedge.
module tb_morse_encoder;

    localparam int UNIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_val;
    logic       key_ready;
    logic       morse_out;
    logic       busy;
    logic       overflow;

    int cmp_count = 0;
    int err_count = 0;

    logic exp_mo [0:1023];
    logic exp_bz [0:1023];
    int   exp_len;

    string patterns [16] = '{"-----", ".----", "..---", "...--", "....-", ".....",
                             "-....", "--...", "---..", "----.", ".-", "-...",
                             "-.-.", "-..", ".", "..-."};

    morse_encoder #(.UNIT_CYCLES(UNIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_val   (key_val),
        .key_ready (key_ready),
        .morse_out (morse_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic exp_push(input logic mo, input logic bz, input int n);
        for (int j = 0; j < n; j++) begin
            exp_mo[exp_len] = mo;
            exp_bz[exp_len] = bz;
            exp_len++;
        end
    endtask

    // Two idle samples precede the first mark after the write edge.
    task automatic exp_start();
        exp_len = 0;
        exp_push(1'b0, 1'b0, 2);
    endtask

    // One character: marks and gaps, a 3-unit character gap, then one idle cycle.
    task automatic exp_char(input logic [3:0] code);
        string p;
        p = patterns[code];
        for (int s = 0; s < p.len(); s++) begin
            exp_push(1'b1, 1'b1, (p.substr(s, s) == "-") ? 3 * UNIT : UNIT);
            if (s != p.len() - 1) begin
                exp_push(1'b0, 1'b1, UNIT);
            end
        end
        exp_push(1'b0, 1'b1, 3 * UNIT);
        exp_push(1'b0, 1'b0, 1);
    endtask

    task automatic write_code(input logic [3:0] code);
        key_valid = 1'b1;
        key_val   = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic settle();
        int quiet;
        quiet = 0;
        for (int c = 0; c < 500 && quiet < 3; c++) begin
            if (busy === 1'b0) quiet++;
            else quiet = 0;
            @(posedge clk);
            #1;
        end
        cmp_count++;
        if (quiet < 3) begin
            err_count++;
            $display("[TB] FAIL settle: busy still %b, required 0 within 500 cycles", busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_val   = 4'h0;
        #1;
        cmp_count++;
        if (morse_out !== 1'b0) begin err_count++; $display("[TB] FAIL rst_morse: got %b want 0", morse_out); end
        cmp_count++;
        if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        cmp_count++;
        if (overflow !== 1'b0) begin err_count++; $display("[TB] FAIL rst_overflow: got %b want 0", overflow); end
        cmp_count++;
        if (key_ready !== 1'b1) begin err_count++; $display("[TB] FAIL rst_ready: got %b want 1", key_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_count++;
        if (busy !== 1'b0 || key_ready !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL post_rst: busy %b ready %b, want busy 0 ready 1", busy, key_ready);
        end
    endtask

    task automatic test_char_e();
        exp_start();
        exp_char(4'hE);
        write_code(4'hE);
        for (int i = 0; i < 24; i++) begin
            cmp_count++;
            if (morse_out !== ((i < exp_len) ? exp_mo[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL e_morse[%0d]: got %b", i, morse_out);
            end
            cmp_count++;
            if (busy !== ((i < exp_len) ? exp_bz[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL e_busy[%0d]: got %b", i, busy);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // key_val is scrambled right after the write edge; the A must still go out.
    task automatic test_char_a_hold();
        exp_start();
        exp_char(4'hA);
        write_code(4'hA);
        key_val = 4'h5;
        for (int i = 0; i < 38; i++) begin
            cmp_count++;
            if (morse_out !== ((i < exp_len) ? exp_mo[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL a_morse[%0d]: got %b", i, morse_out);
            end
            cmp_count++;
            if (busy !== ((i < exp_len) ? exp_bz[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL a_busy[%0d]: got %b", i, busy);
            end
            key_val = 4'(i);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_overflow();
        exp_start();
        exp_char(4'hE);
        exp_char(4'h1);
        exp_char(4'h2);
        exp_char(4'h3);
        exp_char(4'h4);
        write_code(4'hE);
        for (int i = 0; i < 300; i++) begin
            cmp_count++;
            if (morse_out !== ((i < exp_len) ? exp_mo[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL ovf_morse[%0d]: got %b", i, morse_out);
            end
            cmp_count++;
            if (busy !== ((i < exp_len) ? exp_bz[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL ovf_busy[%0d]: got %b", i, busy);
            end
            cmp_count++;
            if (overflow !== (i == 6)) begin
                err_count++; $display("[TB] FAIL ovf_pulse[%0d]: got %b want %b", i, overflow, (i == 6));
            end
            if (i == 4 || i == 5) begin
                cmp_count++;
                if (key_ready !== (i == 4)) begin
                    err_count++; $display("[TB] FAIL ovf_ready[%0d]: got %b want %b", i, key_ready, (i == 4));
                end
            end
            if (i >= 1 && i <= 5) begin
                key_valid = 1'b1;
                key_val   = 4'(i);
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // FIFO full, key_valid held: the pop at edge 18 frees a slot, A lands at edge 19.
    task automatic test_full_hold();
        exp_start();
        for (int c = 0; c < 5; c++) exp_char(4'hE);
        exp_char(4'hA);
        write_code(4'hE);
        for (int i = 0; i < 125; i++) begin
            cmp_count++;
            if (morse_out !== ((i < exp_len) ? exp_mo[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL hold_morse[%0d]: got %b", i, morse_out);
            end
            cmp_count++;
            if (busy !== ((i < exp_len) ? exp_bz[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL hold_busy[%0d]: got %b", i, busy);
            end
            cmp_count++;
            if (overflow !== (i >= 6 && i <= 18)) begin
                err_count++; $display("[TB] FAIL hold_ovf[%0d]: got %b want %b", i, overflow, (i >= 6 && i <= 18));
            end
            if (i >= 17 && i <= 19) begin
                cmp_count++;
                if (key_ready !== (i == 18)) begin
                    err_count++; $display("[TB] FAIL hold_ready[%0d]: got %b want %b", i, key_ready, (i == 18));
                end
            end
            key_valid = (i >= 1 && i <= 18);
            key_val   = (i >= 5) ? 4'hA : 4'hE;
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
    endtask

    task automatic test_reset_mid_char();
        exp_start();
        exp_char(4'h0);
        write_code(4'h0);
        for (int i = 0; i < 21; i++) begin
            cmp_count++;
            if (morse_out !== exp_mo[i]) begin
                err_count++; $display("[TB] FAIL mid_morse[%0d]: got %b want %b", i, morse_out, exp_mo[i]);
            end
            key_valid = (i == 1);
            key_val   = 4'h7;
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp_count++;
        if (morse_out !== 1'b0) begin err_count++; $display("[TB] FAIL async_morse: got %b want 0", morse_out); end
        cmp_count++;
        if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL async_busy: got %b want 0", busy); end
        cmp_count++;
        if (key_ready !== 1'b1) begin err_count++; $display("[TB] FAIL async_ready: got %b want 1", key_ready); end
        repeat (2) @(posedge clk);
        #1;
        cmp_count++;
        if (morse_out !== 1'b0 || busy !== 1'b0) begin
            err_count++; $display("[TB] FAIL hold_rst: morse %b busy %b want 0 0", morse_out, busy);
        end
        rst_n = 1'b1;
        exp_start();
        exp_char(4'hE);
        write_code(4'hE);
        for (int i = 0; i < 40; i++) begin
            cmp_count++;
            if (morse_out !== ((i < exp_len) ? exp_mo[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL after_rst_morse[%0d]: got %b", i, morse_out);
            end
            cmp_count++;
            if (busy !== ((i < exp_len) ? exp_bz[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL after_rst_busy[%0d]: got %b", i, busy);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_start();
        exp_char(4'hE);
        exp_char(4'hE);
        write_code(4'hE);
        for (int i = 0; i < 42; i++) begin
            cmp_count++;
            if (morse_out !== ((i < exp_len) ? exp_mo[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL b2b_morse[%0d]: got %b", i, morse_out);
            end
            cmp_count++;
            if (busy !== ((i < exp_len) ? exp_bz[i] : 1'b0)) begin
                err_count++; $display("[TB] FAIL b2b_busy[%0d]: got %b", i, busy);
            end
            key_valid = (i == 10);
            key_val   = 4'hE;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_char_e();
        settle();
        test_char_a_hold();
        settle();
        test_overflow();
        settle();
        test_full_hold();
        settle();
        test_reset_mid_char();
        settle();
        test_back_to_back();
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 Parameter UNIT_CYCLES, default 5000000, gives the Morse time unit in clk cycles; legal range is 2 to 2^24-1.
REQ-002 Port clk, input, 1 bit: the single system clock; every register in the block is clocked on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port key_valid, input, 1 bit: a key code is offered this cycle.
REQ-005 Port key_val, input, 4 bits: hex key code 0x0 to 0xF, as produced by the keypad scanner.
REQ-006 Port key_ready, output, 1 bit: the FIFO can accept a code this cycle.
REQ-007 Port morse_out, output, 1 bit, registered: tone/LED drive, where 1 means mark.
REQ-008 Port busy, output, 1 bit, registered: a character is being sent, including its trailing gap.
REQ-009 Port overflow, output, 1 bit, registered: one-cycle pulse when key_valid is asserted while key_ready is 0.

Function
REQ-010 The block shall hold a 4-entry FIFO of key codes; a write occurs on any rising edge where key_valid and key_ready are both 1.
REQ-011 key_ready shall equal the inverse of FIFO full, as a combinational function of registered occupancy only.
REQ-012 A write attempt while full shall drop the code, leave the FIFO unchanged, and pulse overflow for 1 cycle.
REQ-013 When a push and a pop occur in the same cycle, both shall take effect and occupancy shall stay unchanged.
REQ-014 Read and write pointers shall be 2 bits wide and wrap from 3 to 0; occupancy shall be 3 bits wide.
REQ-015 FSM states are IDLE, MARK, GAP and CGAP.
  - IDLE, FIFO non-empty: pop the head, load that character's length and pattern, go to MARK.
  - IDLE, FIFO empty: stay in IDLE.
REQ-016 The pattern table (MSB first, 1 = dash) shall be:
  - 1 .----, 2 ..---, 3 ...--, 4 ....-, 5 .....
  - 6 -...., 7 --..., 8 ---.., 9 ----., 0 -----
  - A .-, B -..., C -.-., D -.., E ., F ..-.
REQ-017 MARK: morse_out shall be 1 for UNIT_CYCLES cycles for a dot and 3*UNIT_CYCLES cycles for a dash.
  - Then go to GAP if symbols remain.
  - Otherwise go to CGAP.
REQ-018 GAP: morse_out shall be 0 for UNIT_CYCLES cycles, then the next symbol starts in MARK.
REQ-019 CGAP: morse_out shall be 0 for 3*UNIT_CYCLES cycles, then the FSM returns to IDLE.
REQ-020 The unit counter shall be 24 bits wide and the symbol counter 3 bits wide; the unit counter reloads on every state entry.
REQ-021 Latency: for a code written at edge k into an empty FIFO with the FSM in IDLE:
  - pop occurs at edge k+1;
  - morse_out and busy first read 1 after edge k+2.
REQ-022 busy shall be 1 in MARK, GAP and CGAP, and 0 in IDLE.
REQ-023 When CGAP ends with the FIFO non-empty, the FSM shall pass through IDLE for exactly 1 cycle, then pop the next code.
REQ-024 key_val shall be sampled only at the write edge; changes after that edge shall not affect a character in flight.

Reset
REQ-025 While rst_n = 0, the block shall hold:
  - FSM in IDLE, FIFO empty, both pointers 0;
  - all counters 0;
  - morse_out = 0, busy = 0, overflow = 0, key_ready = 1.
REQ-026 Reset asserted mid-character shall drive morse_out to 0 immediately (asynchronously) and discard all queued codes.
REQ-027 After rst_n deasserts, the first write is accepted on the first rising edge where key_valid = 1.

Verification (UNIT_CYCLES = 4)
REQ-028 Write 0xE into an idle block:
  - morse_out is 1 for 4 cycles, then 0 for 12 cycles;
  - busy is 1 for 16 cycles, then 0.
REQ-029 Write 0xA: morse_out shows 1 for 4 cycles, 0 for 4, 1 for 12, then 0 for 12; busy is 1 for 32 cycles in total.
REQ-030 Write 0x1, 0x2, 0x3, 0x4, 0x5 on back-to-back cycles while the FSM is in MARK with 0 codes queued:
  - 5th write sees key_ready = 0, overflow pulses once, and the code is dropped;
  - outputs are characters 1, 2, 3, 4 in order, each separated by a 12-cycle CGAP plus 1 IDLE cycle.
REQ-031 With the FIFO full, key_valid held across the pop cycle: the pop frees an entry, and the write is accepted on the following edge.
REQ-032 Write 0x0, assert rst_n = 0 in the 2nd dash, deassert, then write 0xE:
  - morse_out falls to 0 without waiting for a clock edge;
  - busy = 0 and key_ready = 1 during reset;
  - only the 0xE character is then sent.
REQ-033 Write 0xE, wait 10 cycles, then write 0xE again: the 2nd character's first mark starts exactly 1 IDLE cycle after the 1st CGAP ends.
